// File: rtl/task_scheduler.sv
// Multi-task sequencer: walks every enabled task in ascending order, feeding TV-in bytes
// from the input FIFO and collecting answer words into per-task output address windows.
module task_scheduler #(
    parameter int                NUM_TASKS  = 16,
    parameter logic [31:0]       TASK_MASK  = 32'h0000_0211,
    parameter int                DIN_W      = 8,
    parameter int                DOUT_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                LEN_W      = 12,
    parameter logic [ADDR_W-1:0] OUT_BASE   = 32'hA000_0800,
    parameter logic [ADDR_W-1:0] OUT_STRIDE = 32'h0000_0100,
    parameter int                TIMEOUT    = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic [NUM_TASKS*LEN_W-1:0]  i_in_len,
    input  logic [NUM_TASKS*LEN_W-1:0]  i_out_len,
    input  logic [DIN_W-1:0]            i_fifo_data,
    input  logic                        i_fifo_valid,
    output logic                        o_fifo_rd,
    output logic [NUM_TASKS-1:0]        o_task_sel,
    output logic [DIN_W-1:0]            o_task_data,
    output logic                        o_task_valid,
    output logic                        o_task_last,
    input  logic [NUM_TASKS-1:0]        i_task_ready,
    input  logic [NUM_TASKS*DOUT_W-1:0] i_task_ans,
    input  logic [NUM_TASKS-1:0]        i_task_ans_valid,
    output logic                        o_task_ans_ready,
    output logic [ADDR_W-1:0]           o_wr_addr,
    output logic [DOUT_W-1:0]           o_wr_data,
    output logic                        o_wr_valid,
    input  logic                        i_wr_ready,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [4:0]                  o_cur_task,
    output logic [NUM_TASKS-1:0]        o_timeout_mask
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_FEED,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           cur_q;
    logic [5:0]           start_idx_q;
    logic [LEN_W-1:0]     byte_cnt_q;
    logic [LEN_W-1:0]     word_cnt_q;
    logic [WD_W-1:0]      wdog_q;
    logic [NUM_TASKS-1:0] tmo_mask_q;

    logic                 wr_vld_p1;
    logic [ADDR_W-1:0]    wr_addr_p1;
    logic [DOUT_W-1:0]    wr_data_p1;

    logic [LEN_W-1:0]     in_len_cur, out_len_cur;
    logic [DOUT_W-1:0]    ans_cur;
    logic                 ans_vld_cur, rdy_cur;
    logic                 found;
    logic [4:0]           found_idx;
    logic                 in_feed, in_drain;
    logic                 task_vld, fifo_rd, last_byte, ans_acc;
    logic                 feed_stall, drain_stall, timeout_hit;

    function automatic logic [ADDR_W-1:0] win_addr(input logic [4:0] idx,
                                                   input logic [LEN_W-1:0] k);
        win_addr = OUT_BASE + ADDR_W'(idx) * OUT_STRIDE + ADDR_W'(k) * ADDR_W'(DOUT_W / 8);
    endfunction

    always_comb begin
        in_len_cur  = '0;
        out_len_cur = '0;
        ans_cur     = '0;
        ans_vld_cur = 1'b0;
        rdy_cur     = 1'b0;
        for (int i = 0; i < NUM_TASKS; i++) begin
            if (cur_q == 5'(i)) begin
                in_len_cur  = i_in_len[i*LEN_W +: LEN_W];
                out_len_cur = i_out_len[i*LEN_W +: LEN_W];
                ans_cur     = i_task_ans[i*DOUT_W +: DOUT_W];
                ans_vld_cur = i_task_ans_valid[i];
                rdy_cur     = i_task_ready[i];
            end
        end
    end

    // Descending scan so the lowest enabled index at or above start_idx_q wins.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = NUM_TASKS - 1; i >= 0; i--) begin
            if (TASK_MASK[i] && (6'(i) >= start_idx_q)) begin
                found     = 1'b1;
                found_idx = 5'(i);
            end
        end
    end

    assign in_feed     = (state_q == S_FEED);
    assign in_drain    = (state_q == S_DRAIN);
    assign task_vld    = in_feed & i_fifo_valid & (in_len_cur != '0);
    assign fifo_rd     = task_vld & rdy_cur;
    assign last_byte   = (byte_cnt_q == in_len_cur - LEN_W'(1));
    assign ans_acc     = in_drain & ans_vld_cur & (~wr_vld_p1 | i_wr_ready) &
                         (word_cnt_q < out_len_cur);
    assign feed_stall  = task_vld & ~fifo_rd;
    assign drain_stall = in_drain & ~wr_vld_p1 & ~ans_acc;
    assign timeout_hit = (feed_stall | drain_stall) && (wdog_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (i_start) state_d = S_SELECT;
            S_SELECT:       state_d = found ? S_FEED : S_DONE;
            S_FEED: begin
                if (timeout_hit)
                    state_d = S_NEXT;
                else if ((in_len_cur == '0) || (fifo_rd && last_byte))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (timeout_hit)
                    state_d = S_NEXT;
                else if ((word_cnt_q == out_len_cur) && !wr_vld_p1)
                    state_d = S_NEXT;
            end
            S_NEXT:         state_d = S_SELECT;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cur_q       <= '0;
            start_idx_q <= '0;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            wdog_q      <= '0;
            tmo_mask_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        tmo_mask_q  <= '0;
                        start_idx_q <= '0;
                    end
                end
                S_SELECT: begin
                    if (found) begin
                        cur_q      <= found_idx;
                        byte_cnt_q <= '0;
                        word_cnt_q <= '0;
                        wdog_q     <= '0;
                    end
                end
                S_FEED: begin
                    if (fifo_rd) begin
                        byte_cnt_q <= byte_cnt_q + LEN_W'(1);
                        wdog_q     <= '0;
                    end else if (feed_stall) begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                    if (state_d == S_DRAIN)
                        wdog_q <= '0;
                    if (timeout_hit)
                        tmo_mask_q[cur_q] <= 1'b1;
                end
                S_DRAIN: begin
                    if (ans_acc) begin
                        word_cnt_q <= word_cnt_q + LEN_W'(1);
                        wdog_q     <= '0;
                    end else if (drain_stall) begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                    if (timeout_hit)
                        tmo_mask_q[cur_q] <= 1'b1;
                end
                S_NEXT: start_idx_q <= {1'b0, cur_q} + 6'd1;
                default: ;
            endcase
        end
    end

    // p1: one-entry write register, loaded on answer accept, held until the sink takes it
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else if (ans_acc) begin
            wr_vld_p1  <= 1'b1;
            wr_addr_p1 <= win_addr(cur_q, word_cnt_q);
            wr_data_p1 <= ans_cur;
        end else if (i_wr_ready) begin
            wr_vld_p1 <= 1'b0;
        end
    end

    always_comb begin
        o_task_sel = '0;
        if (in_feed || in_drain)
            o_task_sel = NUM_TASKS'(1) << cur_q;
        o_busy = (state_q == S_SELECT) || in_feed || in_drain || (state_q == S_NEXT);
        o_done = (state_q == S_DONE);
    end

    assign o_fifo_rd        = fifo_rd;
    assign o_task_valid     = task_vld;
    assign o_task_data      = in_feed ? i_fifo_data : '0;
    assign o_task_last      = task_vld & last_byte;
    assign o_task_ans_ready = ans_acc;
    assign o_wr_valid       = wr_vld_p1;
    assign o_wr_addr        = wr_addr_p1;
    assign o_wr_data        = wr_data_p1;
    assign o_cur_task       = cur_q;
    assign o_timeout_mask   = tmo_mask_q;

endmodule

// File: tb/tb_task_scheduler.sv
// Scoreboard bench for task_scheduler: expected writes are queued per scenario and
// matched against each accepted write; task order, pops and watchdog behaviour checked.
module tb_task_scheduler;

    localparam int NT = 16;
    localparam int LW = 12;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              i_rst_n, i_start;
    logic [NT*LW-1:0]  i_in_len, i_out_len;
    logic [7:0]        i_fifo_data;
    logic              i_fifo_valid;
    logic              o_fifo_rd;
    logic [NT-1:0]     o_task_sel;
    logic [7:0]        o_task_data;
    logic              o_task_valid, o_task_last;
    logic [NT-1:0]     i_task_ready;
    logic [NT*DW-1:0]  i_task_ans;
    logic [NT-1:0]     i_task_ans_valid;
    logic              o_task_ans_ready;
    logic [31:0]       o_wr_addr;
    logic [31:0]       o_wr_data;
    logic              o_wr_valid, i_wr_ready;
    logic              o_busy, o_done;
    logic [4:0]        o_cur_task;
    logic [NT-1:0]     o_timeout_mask;

    always #5 clk = ~clk;

    task_scheduler #(.NUM_TASKS(NT), .TASK_MASK(32'h0000_0211), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_in_len(i_in_len), .i_out_len(i_out_len),
        .i_fifo_data(i_fifo_data), .i_fifo_valid(i_fifo_valid), .o_fifo_rd(o_fifo_rd),
        .o_task_sel(o_task_sel), .o_task_data(o_task_data), .o_task_valid(o_task_valid),
        .o_task_last(o_task_last), .i_task_ready(i_task_ready), .i_task_ans(i_task_ans),
        .i_task_ans_valid(i_task_ans_valid), .o_task_ans_ready(o_task_ans_ready),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_valid(o_wr_valid),
        .i_wr_ready(i_wr_ready), .o_busy(o_busy), .o_done(o_done),
        .o_cur_task(o_cur_task), .o_timeout_mask(o_timeout_mask)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          vecs = 0;
    int          errs = 0;
    wr_t         exp_q[$];
    int          order[$];
    int          cyc = 0, pops = 0, writes = 0, task_bytes = 0;
    int          ans_k[NT];
    int          sel_cycles[NT];
    int          bin_len[NT];
    logic [7:0]  pop_byte = 8'h00;
    logic        fifo_en = 1'b1;
    logic        wr_mode = 1'b0;
    logic [NT-1:0] rdy_mask = '1;
    logic [NT-1:0] ans_mask = '1;
    logic [NT-1:0] last_sel = '0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_addr, hold_data;

    function automatic logic [31:0] ans_word(int t, int k);
        return {8'(t), 8'h5A, 16'(k)};
    endfunction

    function automatic logic [31:0] exp_addr(int t, int k);
        return 32'hA000_0800 + 32'(t) * 32'h100 + 32'(k) * 32'd4;
    endfunction

    task automatic set_lens(int t, int il, int ol);
        i_in_len[t*LW +: LW]  = LW'(il);
        i_out_len[t*LW +: LW] = LW'(ol);
        bin_len[t] = il;
    endtask

    task automatic push_task(int t, int nwords);
        for (int k = 0; k < nwords; k++) exp_q.push_back('{exp_addr(t, k), ans_word(t, k)});
    endtask

    task automatic arm();
        exp_q.delete();
        order.delete();
        pops = 0; writes = 0; task_bytes = 0;
        last_sel = '0; hold_pend = 1'b0;
        for (int t = 0; t < NT; t++) begin ans_k[t] = 0; sel_cycles[t] = 0; end
    endtask

    // Drive inputs at negedge, then observe the handshakes that the next posedge will take.
    task automatic cycle();
        int  idx;
        wr_t e;
        logic exp_last;
        @(negedge clk);
        cyc++;
        i_start          = 1'b0;
        i_wr_ready       = wr_mode ? (cyc % 3 == 0) : 1'b1;
        i_fifo_valid     = fifo_en;
        i_fifo_data      = pop_byte;
        i_task_ready     = rdy_mask;
        i_task_ans_valid = ans_mask;
        for (int t = 0; t < NT; t++) i_task_ans[t*DW +: DW] = ans_word(t, ans_k[t]);
        #1;
        idx = -1;
        for (int t = 0; t < NT; t++) if (o_task_sel[t]) idx = t;
        if (idx >= 0) begin
            sel_cycles[idx]++;
            if (o_task_sel != last_sel) begin order.push_back(idx); task_bytes = 0; end
        end
        last_sel = o_task_sel;
        if (o_fifo_rd) begin
            vecs++;
            exp_last = (idx >= 0) && (task_bytes == bin_len[idx] - 1);
            if (!i_fifo_valid || o_task_data !== pop_byte || o_task_last !== exp_last) begin
                errs++;
                $display("FAIL feed_byte: data=%h last=%b fifo_valid=%b, expected data=%h last=%b",
                         o_task_data, o_task_last, i_fifo_valid, pop_byte, exp_last);
            end
            task_bytes++; pops++; pop_byte++;
        end
        if (o_task_ans_ready) begin
            vecs++;
            if (idx < 0 || !ans_mask[idx]) begin
                errs++;
                $display("FAIL ans_ready: asserted with sel=%h ans_valid=%h", o_task_sel, ans_mask);
            end else ans_k[idx]++;
        end
        if (hold_pend) begin
            vecs++;
            if (o_wr_valid !== 1'b1 || o_wr_addr !== hold_addr || o_wr_data !== hold_data) begin
                errs++;
                $display("FAIL wr_hold: valid=%b addr=%h data=%h, expected 1 %h %h",
                         o_wr_valid, o_wr_addr, o_wr_data, hold_addr, hold_data);
            end
        end
        hold_pend = o_wr_valid && !i_wr_ready;
        hold_addr = o_wr_addr;
        hold_data = o_wr_data;
        if (o_wr_valid && i_wr_ready) begin
            vecs++; writes++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL wr_unexpected: addr=%h data=%h, expected no write", o_wr_addr, o_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (o_wr_addr !== e.addr || o_wr_data !== e.data) begin
                    errs++;
                    $display("FAIL wr_word: addr=%h data=%h, expected addr=%h data=%h",
                             o_wr_addr, o_wr_data, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic start_pass();
        i_start = 1'b1;
        cycle();
    endtask

    task automatic wait_done(int budget, string name);
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (o_done === 1'b1) break;
        end
        vecs++;
        if (o_done !== 1'b1) begin
            errs++;
            $display("FAIL %s_done: o_done=%b after %0d cycles, expected 1", name, o_done, budget);
        end
    endtask

    task automatic check_pass(string name, int exp_pops, int exp_writes, int t0, int t1, int t2);
        vecs++;
        if (exp_q.size() != 0 || writes != exp_writes || pops != exp_pops) begin
            errs++;
            $display("FAIL %s_totals: left=%0d writes=%0d pops=%0d, expected 0 %0d %0d",
                     name, exp_q.size(), writes, pops, exp_writes, exp_pops);
        end
        vecs++;
        if (order.size() != 3) begin
            errs++;
            $display("FAIL %s_order: %0d tasks run, expected 3", name, order.size());
        end else if (order[0] != t0 || order[1] != t1 || order[2] != t2) begin
            errs++;
            $display("FAIL %s_order: %0d,%0d,%0d expected %0d,%0d,%0d",
                     name, order[0], order[1], order[2], t0, t1, t2);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        cycle();
        cycle();
        vecs++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_wr_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_status: busy=%b done=%b wr_valid=%b, expected 0 0 0", o_busy, o_done, o_wr_valid);
        end
        vecs++;
        if (o_task_sel !== '0 || o_timeout_mask !== '0 || o_cur_task !== 5'd0) begin
            errs++;
            $display("FAIL reset_regs: sel=%h mask=%h cur=%0d, expected 0 0 0", o_task_sel, o_timeout_mask, o_cur_task);
        end
        vecs++;
        if (o_fifo_rd !== 1'b0 || o_task_valid !== 1'b0 || o_task_ans_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_handshake: rd=%b tvalid=%b ans_ready=%b, expected 0 0 0",
                     o_fifo_rd, o_task_valid, o_task_ans_ready);
        end
        i_rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        arm();
        push_task(0, 2); push_task(4, 2); push_task(9, 2);
        start_pass();
        vecs++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            errs++;
            $display("FAIL basic_busy: busy=%b done=%b, expected 1 0", o_busy, o_done);
        end
        wait_done(300, "basic");
        check_pass("basic", 12, 6, 0, 4, 9);
        cycle();
        vecs++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_timeout_mask !== '0) begin
            errs++;
            $display("FAIL basic_level: done=%b busy=%b mask=%h, expected 1 0 0", o_done, o_busy, o_timeout_mask);
        end
    endtask

    task automatic test_wr_stall();
        arm();
        wr_mode = 1'b1;
        push_task(0, 2); push_task(4, 2); push_task(9, 2);
        start_pass();
        wait_done(400, "wr_stall");
        check_pass("wr_stall", 12, 6, 0, 4, 9);
        wr_mode = 1'b0;
    endtask

    task automatic test_timeout();
        arm();
        rdy_mask = ~16'h0010;
        push_task(0, 2); push_task(9, 2);
        start_pass();
        wait_done(400, "timeout");
        check_pass("timeout", 8, 4, 0, 4, 9);
        vecs++;
        if (o_timeout_mask !== 16'h0010 || sel_cycles[4] != 16) begin
            errs++;
            $display("FAIL timeout_mask: mask=%h task4_cycles=%0d, expected 0010 16", o_timeout_mask, sel_cycles[4]);
        end
        rdy_mask = '1;
    endtask

    task automatic test_restart();
        arm();
        push_task(0, 2); push_task(4, 2); push_task(9, 2);
        start_pass();
        vecs++;
        if (o_timeout_mask !== '0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            errs++;
            $display("FAIL restart_clear: mask=%h busy=%b done=%b, expected 0 1 0", o_timeout_mask, o_busy, o_done);
        end
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (i % 7 == 3) i_start = 1'b1;
        end
        wait_done(300, "restart");
        check_pass("restart", 12, 6, 0, 4, 9);
        arm();
        push_task(0, 2); push_task(4, 2); push_task(9, 2);
        start_pass();
        vecs++;
        if (o_done !== 1'b0 || o_busy !== 1'b1) begin
            errs++;
            $display("FAIL restart_from_done: done=%b busy=%b, expected 0 1", o_done, o_busy);
        end
        wait_done(300, "restart2");
        check_pass("restart2", 12, 6, 0, 4, 9);
    endtask

    task automatic test_zero_len();
        arm();
        set_lens(0, 0, 0);
        push_task(4, 2); push_task(9, 2);
        start_pass();
        wait_done(300, "zero_len");
        check_pass("zero_len", 8, 4, 0, 4, 9);
        vecs++;
        if (sel_cycles[0] != 2) begin
            errs++;
            $display("FAIL zero_len_skip: task0 active %0d cycles, expected 2", sel_cycles[0]);
        end
        set_lens(0, 4, 2);
    endtask

    task automatic test_reset_mid_drain();
        bit seen;
        arm();
        rdy_mask = ~16'h0001;
        push_task(4, 2);
        start_pass();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cycle();
            seen = (o_wr_valid === 1'b1);
        end
        vecs++;
        if (!seen || o_timeout_mask !== 16'h0001) begin
            errs++;
            $display("FAIL mid_drain_reach: wr_seen=%b mask=%h, expected 1 0001", seen, o_timeout_mask);
        end
        i_rst_n = 1'b0;
        cycle();
        vecs++;
        if (o_wr_valid !== 1'b0 || o_busy !== 1'b0 || o_timeout_mask !== '0 ||
            o_done !== 1'b0 || o_task_sel !== '0) begin
            errs++;
            $display("FAIL mid_drain_reset: wr_valid=%b busy=%b mask=%h done=%b sel=%h, expected all 0",
                     o_wr_valid, o_busy, o_timeout_mask, o_done, o_task_sel);
        end
        i_rst_n = 1'b1;
        exp_q.delete();
        rdy_mask = '1;
        cycle();
        vecs++;
        if (o_busy !== 1'b0 || o_wr_valid !== 1'b0) begin
            errs++;
            $display("FAIL mid_drain_idle: busy=%b wr_valid=%b, expected 0 0", o_busy, o_wr_valid);
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0;
        i_fifo_valid = 1'b0; i_fifo_data = '0;
        i_task_ready = '0; i_task_ans = '0; i_task_ans_valid = '0; i_wr_ready = 1'b0;
        i_in_len = '0; i_out_len = '0;
        for (int t = 0; t < NT; t++) set_lens(t, 4, 2);
        test_reset();
        test_basic();
        test_wr_stall();
        test_timeout();
        test_restart();
        test_zero_len();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
